mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle control FSM for the MIPS core. It sequences one instruction at a time through FETCH/DECODE/EXEC/MEM/WB, so a single ALU and a single-write-port GRF are shared across cycles. It drives IR/PC write enables, GRF write enable and write-address/data selects, ALU and extender controls, and DM write enable. It sits between the IR-decoded fields (opcode/funct, held by the datapath IR) and the datapath muxes.

Parameters:
FETCH_WAIT, 0, extra IM wait cycles spent in FETCH before IR/PC are written (0..15)
CNT_W, 4, width of the FETCH wait counter

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
opcode  in  6  IR[31:26]; valid from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, valid in EXEC
state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
irWrite  out  1  latch IM output into IR
pcWrite  out  1  PC update enable
pcSrc  out  2  0 PC+4, 1 branch target, 2 jal target, 3 GRF rs (jr)
regWrite  out  1  GRF write enable
regDst  out  2  GRF write address: 0 rt, 1 rd, 2 $31
wdSel  out  2  GRF write data: 0 ALU result, 1 DM read data, 2 PC (already PC+4)
aluSrc  out  1  0 GRF rt, 1 extended immediate
extOp  out  1  1 sign-extend, 0 zero-extend
aluOp  out  2  0 ADD, 1 SUB, 2 OR, 3 LUI (imm<<16)
memWrite  out  1  DM write enable
instrDone  out  1  one-cycle pulse on the last cycle of each instruction
illegal  out  1  one-cycle pulse in DECODE for an unsupported encoding

Behaviour:
- Decode: R-type is opcode 000000 with funct add 100000, addu 100001, sub 100010, subu 100011, jr 001000, or sll 000000 (nop, any shamt). I/J: ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, jal 000011. Anything else is illegal.
- Reset: state=FETCH, wait counter=0. All outputs are 0 in any cycle where reset=1.
- Reset mid-instruction: the instruction is abandoned. No regWrite, memWrite or pcWrite in the reset cycle.
- Every output defaults to 0 (selects to 0) unless it is listed for the current state. Outputs are combinational from state, latched counter and opcode/funct.
- FETCH: the counter counts 0..FETCH_WAIT.
  - While counter<FETCH_WAIT: hold, all outputs 0.
  - When counter==FETCH_WAIT: irWrite=1, pcWrite=1, pcSrc=0, counter<=0, go to DECODE.
  - With FETCH_WAIT=0, FETCH is a single cycle.
- DECODE (GRF read; the datapath latches A/B):
  - jal: regWrite=1, regDst=2, wdSel=2, pcWrite=1, pcSrc=2, instrDone=1, go to FETCH.
  - jr: pcWrite=1, pcSrc=3, instrDone=1, go to FETCH.
  - nop: instrDone=1, go to FETCH.
  - illegal: illegal=1, instrDone=1, go to FETCH. No other side effects; PC has already advanced.
  - Otherwise go to EXEC.
- EXEC:
  - add/addu: aluOp=0, aluSrc=0. sub/subu: aluOp=1, aluSrc=0. Both go to WB.
  - ori: aluOp=2, aluSrc=1, extOp=0, go to WB.
  - lui: aluOp=3, aluSrc=1, go to WB.
  - lw/sw: aluOp=0, aluSrc=1, extOp=1, go to MEM.
  - beq: aluOp=1, aluSrc=0. If zero=1 then pcWrite=1 and pcSrc=1. instrDone=1, go to FETCH.
- MEM:
  - sw: memWrite=1, instrDone=1, go to FETCH.
  - lw: go to WB. DM read data is registered by the datapath.
- WB: regWrite=1, instrDone=1, go to FETCH.
  - R-type: regDst=1, wdSel=0.
  - ori/lui: regDst=0, wdSel=0.
  - lw: regDst=0, wdSel=1.
- Latency with FETCH_WAIT=0:
  - jal, jr, nop, illegal: 2 cycles.
  - beq: 3 cycles.
  - R-type, ori, lui, sw: 4 cycles.
  - lw: 5 cycles.
- FETCH_WAIT adds exactly FETCH_WAIT cycles to every instruction.
- Write to $0 is not suppressed here; the GRF forces $0=0.
- Unused state encodings 5..7 go to FETCH on the next clock with all outputs 0.
- Exactly one of regWrite/memWrite may be high in any cycle. regWrite is high in at most one cycle per instruction.

Test Plan:
- Reset for 2 cycles, then release with FETCH_WAIT=0 and opcode=0, funct=100001 (addu) -> state 0,1,2,4,0; regWrite=1 only in the WB cycle with regDst=1, wdSel=0; instrDone pulses once.
- lw (opcode 100011) -> 5-cycle sequence 0,1,2,3,4; EXEC aluSrc=1, extOp=1, aluOp=0; WB regWrite=1, regDst=0, wdSel=1. sw (101011) -> memWrite=1 in MEM only, never regWrite.
- beq (000100) with zero=1 -> EXEC pcWrite=1, pcSrc=1, back to FETCH after 3 cycles. With zero=0 -> pcWrite=0 in EXEC.
- jal (000011) -> DECODE regWrite=1, regDst=2, wdSel=2, pcWrite=1, pcSrc=2. jr (0/001000) -> pcSrc=3, no regWrite. opcode 111111 -> illegal=1 for one cycle, back to FETCH.
- FETCH_WAIT=3 -> FETCH lasts 4 cycles, with irWrite/pcWrite high only on the 4th. An ori instruction then takes 7 cycles total.
- Assert reset in the WB cycle of an addu -> regWrite=0 that cycle, state=FETCH next cycle, counter=0.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - control bus between the multi-cycle controller and the MIPS datapath
interface mc_ctrl_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic [2:0] state;
   logic       irWrite;
   logic       pcWrite;
   logic [1:0] pcSrc;
   logic       regWrite;
   logic [1:0] regDst;
   logic [1:0] wdSel;
   logic       aluSrc;
   logic       extOp;
   logic [1:0] aluOp;
   logic       memWrite;
   logic       instrDone;
   logic       illegal;

   // master: the controller; slave: the datapath
   modport master (
      input  opcode, funct, zero,
      output state, irWrite, pcWrite, pcSrc, regWrite, regDst, wdSel,
             aluSrc, extOp, aluOp, memWrite, instrDone, illegal
   );

   modport slave (
      output opcode, funct, zero,
      input  state, irWrite, pcWrite, pcSrc, regWrite, regDst, wdSel,
             aluSrc, extOp, aluOp, memWrite, instrDone, illegal
   );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the MIPS core
module mc_ctrl #(
   parameter int FETCH_WAIT = 0,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       reset,
   mc_ctrl_if.master  bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_e;

   typedef enum logic [3:0] {
      C_ILL, C_ADD, C_SUB, C_JR, C_NOP, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL
   } cls_e;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   cls_e             cls;
   logic             fetch_last;

   assign fetch_last = (cnt_q == CNT_W'(FETCH_WAIT));

   always_comb begin
      cls = C_ILL;
      case (bus.opcode)
         6'b000000: begin
            case (bus.funct)
               6'b100000, 6'b100001: cls = C_ADD;
               6'b100010, 6'b100011: cls = C_SUB;
               6'b001000:            cls = C_JR;
               6'b000000:            cls = C_NOP;
               default:              cls = C_ILL;
            endcase
         end
         6'b001101: cls = C_ORI;
         6'b001111: cls = C_LUI;
         6'b100011: cls = C_LW;
         6'b101011: cls = C_SW;
         6'b000100: cls = C_BEQ;
         6'b000011: cls = C_JAL;
         default:   cls = C_ILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_FETCH: begin
            if (fetch_last) begin
               cnt_d   = '0;
               state_d = S_DECODE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DECODE: begin
            case (cls)
               C_JAL, C_JR, C_NOP, C_ILL: state_d = S_FETCH;
               default:                   state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (cls)
               C_ADD, C_SUB, C_ORI, C_LUI: state_d = S_WB;
               C_LW, C_SW:                 state_d = S_MEM;
               default:                    state_d = S_FETCH;
            endcase
         end
         S_MEM:   state_d = (cls == C_LW) ? S_WB : S_FETCH;
         S_WB:    state_d = S_FETCH;
         default: begin
            state_d = S_FETCH;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are forced low in any reset cycle so an abandoned instruction has no side effects
   always_comb begin
      bus.state     = reset ? 3'd0 : state_q;
      bus.irWrite   = 1'b0;
      bus.pcWrite   = 1'b0;
      bus.pcSrc     = 2'd0;
      bus.regWrite  = 1'b0;
      bus.regDst    = 2'd0;
      bus.wdSel     = 2'd0;
      bus.aluSrc    = 1'b0;
      bus.extOp     = 1'b0;
      bus.aluOp     = 2'd0;
      bus.memWrite  = 1'b0;
      bus.instrDone = 1'b0;
      bus.illegal   = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               if (fetch_last) begin
                  bus.irWrite = 1'b1;
                  bus.pcWrite = 1'b1;
               end
            end
            S_DECODE: begin
               case (cls)
                  C_JAL: begin
                     bus.regWrite  = 1'b1;
                     bus.regDst    = 2'd2;
                     bus.wdSel     = 2'd2;
                     bus.pcWrite   = 1'b1;
                     bus.pcSrc     = 2'd2;
                     bus.instrDone = 1'b1;
                  end
                  C_JR: begin
                     bus.pcWrite   = 1'b1;
                     bus.pcSrc     = 2'd3;
                     bus.instrDone = 1'b1;
                  end
                  C_NOP: bus.instrDone = 1'b1;
                  C_ILL: begin
                     bus.illegal   = 1'b1;
                     bus.instrDone = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_EXEC: begin
               case (cls)
                  C_SUB: bus.aluOp = 2'd1;
                  C_ORI: begin
                     bus.aluOp  = 2'd2;
                     bus.aluSrc = 1'b1;
                  end
                  C_LUI: begin
                     bus.aluOp  = 2'd3;
                     bus.aluSrc = 1'b1;
                  end
                  C_LW, C_SW: begin
                     bus.aluSrc = 1'b1;
                     bus.extOp  = 1'b1;
                  end
                  C_BEQ: begin
                     bus.aluOp     = 2'd1;
                     bus.pcWrite   = bus.zero;
                     bus.pcSrc     = bus.zero ? 2'd1 : 2'd0;
                     bus.instrDone = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               if (cls == C_SW) begin
                  bus.memWrite  = 1'b1;
                  bus.instrDone = 1'b1;
               end
            end
            S_WB: begin
               bus.regWrite  = 1'b1;
               bus.instrDone = 1'b1;
               if (cls == C_ADD || cls == C_SUB) bus.regDst = 2'd1;
               if (cls == C_LW)                  bus.wdSel  = 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - table-driven check of mc_ctrl with FETCH_WAIT=0 and FETCH_WAIT=3
module tb_mc_ctrl;

   localparam logic [15:0] IRW  = 16'h8000;
   localparam logic [15:0] PCW  = 16'h4000;
   localparam logic [15:0] PCS1 = 16'h1000;
   localparam logic [15:0] PCS2 = 16'h2000;
   localparam logic [15:0] PCS3 = 16'h3000;
   localparam logic [15:0] RW   = 16'h0800;
   localparam logic [15:0] RD1  = 16'h0200;
   localparam logic [15:0] RD2  = 16'h0400;
   localparam logic [15:0] WD1  = 16'h0080;
   localparam logic [15:0] WD2  = 16'h0100;
   localparam logic [15:0] AS   = 16'h0040;
   localparam logic [15:0] EO   = 16'h0020;
   localparam logic [15:0] AO1  = 16'h0008;
   localparam logic [15:0] AO2  = 16'h0010;
   localparam logic [15:0] AO3  = 16'h0018;
   localparam logic [15:0] MW   = 16'h0004;
   localparam logic [15:0] DN   = 16'h0002;
   localparam logic [15:0] IL   = 16'h0001;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_ORI = 6'b001101;
   localparam logic [5:0] OP_LUI = 6'b001111;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_JAL = 6'b000011;

   typedef struct {
      bit         sel;
      bit         rst;
      logic [5:0] op;
      logic [5:0] fn;
      bit         z;
      logic [2:0] st;
      logic [15:0] ctl;
   } vec_t;

   logic clk = 1'b0;
   logic r0, r1;
   int   errors = 0;
   int   checks = 0;
   vec_t tbl[$];

   mc_ctrl_if i0();
   mc_ctrl_if i1();

   mc_ctrl #(.FETCH_WAIT(0), .CNT_W(4)) dut0 (.clk(clk), .reset(r0), .bus(i0));
   mc_ctrl #(.FETCH_WAIT(3), .CNT_W(4)) dut1 (.clk(clk), .reset(r1), .bus(i1));

   always #5 clk = ~clk;

   function automatic logic [15:0] ctl_of0();
      return {i0.irWrite, i0.pcWrite, i0.pcSrc, i0.regWrite, i0.regDst, i0.wdSel,
              i0.aluSrc, i0.extOp, i0.aluOp, i0.memWrite, i0.instrDone, i0.illegal};
   endfunction

   function automatic logic [15:0] ctl_of1();
      return {i1.irWrite, i1.pcWrite, i1.pcSrc, i1.regWrite, i1.regDst, i1.wdSel,
              i1.aluSrc, i1.extOp, i1.aluOp, i1.memWrite, i1.instrDone, i1.illegal};
   endfunction

   function automatic void add(bit sel, bit rst, logic [5:0] op, logic [5:0] fn, bit z,
                               logic [2:0] st, logic [15:0] ctl);
      vec_t v;
      v.sel = sel; v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.st = st; v.ctl = ctl;
      tbl.push_back(v);
   endfunction

   // One FETCH_WAIT=0 instruction: FETCH, DECODE then the listed tail states
   function automatic void fd(logic [5:0] op, logic [5:0] fn, bit z, logic [15:0] dec);
      add(0, 0, op, fn, z, 3'd0, IRW | PCW);
      add(0, 0, op, fn, z, 3'd1, dec);
   endfunction

   task automatic lat(input logic [5:0] op, input logic [5:0] fn, input int expc, input string nm);
      int  cyc;
      bit  done;
      @(negedge clk);
      r0 = 1'b1;
      @(negedge clk);
      r0 = 1'b0;
      i0.opcode = op; i0.funct = fn; i0.zero = 1'b1;
      cyc = 0;
      done = 1'b0;
      while (!done && cyc < 20) begin
         #1;
         cyc++;
         if (i0.instrDone) done = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!done || cyc != expc) begin
         errors++;
         $display("FAIL lat_%s: got %0d cycles (done=%0d), expected %0d", nm, cyc, done, expc);
      end
   endtask

   initial begin
      logic [2:0]  got_st;
      logic [15:0] got_ctl;
      r0 = 1'b1; r1 = 1'b1;
      i0.opcode = '0; i0.funct = '0; i0.zero = 1'b0;
      i1.opcode = '0; i1.funct = '0; i1.zero = 1'b0;

      add(0, 1, OP_R, 6'b100001, 0, 3'd0, 16'h0);
      add(0, 1, OP_R, 6'b100001, 0, 3'd0, 16'h0);
      fd(OP_R, 6'b100001, 0, 16'h0);
      add(0, 0, OP_R, 6'b100001, 0, 3'd2, 16'h0);
      add(0, 0, OP_R, 6'b100001, 0, 3'd4, RW | RD1 | DN);
      fd(OP_R, 6'b100010, 0, 16'h0);
      add(0, 0, OP_R, 6'b100010, 0, 3'd2, AO1);
      add(0, 0, OP_R, 6'b100010, 0, 3'd4, RW | RD1 | DN);
      fd(OP_LW, 6'b000000, 0, 16'h0);
      add(0, 0, OP_LW, 6'b000000, 0, 3'd2, AS | EO);
      add(0, 0, OP_LW, 6'b000000, 0, 3'd3, 16'h0);
      add(0, 0, OP_LW, 6'b000000, 0, 3'd4, RW | WD1 | DN);
      fd(OP_SW, 6'b000000, 0, 16'h0);
      add(0, 0, OP_SW, 6'b000000, 0, 3'd2, AS | EO);
      add(0, 0, OP_SW, 6'b000000, 0, 3'd3, MW | DN);
      fd(OP_BEQ, 6'b000000, 1, 16'h0);
      add(0, 0, OP_BEQ, 6'b000000, 1, 3'd2, AO1 | PCW | PCS1 | DN);
      fd(OP_BEQ, 6'b000000, 0, 16'h0);
      add(0, 0, OP_BEQ, 6'b000000, 0, 3'd2, AO1 | DN);
      fd(OP_JAL, 6'b000000, 0, RW | RD2 | WD2 | PCW | PCS2 | DN);
      fd(OP_R, 6'b001000, 0, PCW | PCS3 | DN);
      fd(OP_R, 6'b000000, 0, DN);
      fd(6'b111111, 6'b000000, 0, IL | DN);
      fd(OP_R, 6'b101010, 0, IL | DN);
      fd(OP_ORI, 6'b000000, 0, 16'h0);
      add(0, 0, OP_ORI, 6'b000000, 0, 3'd2, AO2 | AS);
      add(0, 0, OP_ORI, 6'b000000, 0, 3'd4, RW | DN);
      fd(OP_LUI, 6'b000000, 0, 16'h0);
      add(0, 0, OP_LUI, 6'b000000, 0, 3'd2, AO3 | AS);
      add(0, 0, OP_LUI, 6'b000000, 0, 3'd4, RW | DN);
      // reset lands on the WB cycle of an addu
      fd(OP_R, 6'b100001, 0, 16'h0);
      add(0, 0, OP_R, 6'b100001, 0, 3'd2, 16'h0);
      add(0, 1, OP_R, 6'b100001, 0, 3'd0, 16'h0);
      add(0, 0, OP_R, 6'b100001, 0, 3'd0, IRW | PCW);

      // FETCH_WAIT=3: ori takes 7 cycles
      add(1, 1, OP_ORI, 6'b000000, 0, 3'd0, 16'h0);
      for (int k = 0; k < 3; k++) add(1, 0, OP_ORI, 6'b000000, 0, 3'd0, 16'h0);
      add(1, 0, OP_ORI, 6'b000000, 0, 3'd0, IRW | PCW);
      add(1, 0, OP_ORI, 6'b000000, 0, 3'd1, 16'h0);
      add(1, 0, OP_ORI, 6'b000000, 0, 3'd2, AO2 | AS);
      add(1, 0, OP_ORI, 6'b000000, 0, 3'd4, RW | DN);
      // reset mid-wait must clear the counter: full 4-cycle FETCH again
      add(1, 0, OP_ORI, 6'b000000, 0, 3'd0, 16'h0);
      add(1, 0, OP_ORI, 6'b000000, 0, 3'd0, 16'h0);
      add(1, 1, OP_ORI, 6'b000000, 0, 3'd0, 16'h0);
      for (int k = 0; k < 3; k++) add(1, 0, OP_ORI, 6'b000000, 0, 3'd0, 16'h0);
      add(1, 0, OP_ORI, 6'b000000, 0, 3'd0, IRW | PCW);
      add(1, 0, OP_ORI, 6'b000000, 0, 3'd1, 16'h0);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         if (tbl[i].sel == 1'b0) begin
            r0 = tbl[i].rst; r1 = 1'b1;
            i0.opcode = tbl[i].op; i0.funct = tbl[i].fn; i0.zero = tbl[i].z;
         end else begin
            r0 = 1'b1; r1 = tbl[i].rst;
            i1.opcode = tbl[i].op; i1.funct = tbl[i].fn; i1.zero = tbl[i].z;
         end
         #1;
         got_st  = tbl[i].sel ? i1.state : i0.state;
         got_ctl = tbl[i].sel ? ctl_of1() : ctl_of0();
         checks++;
         if (got_st !== tbl[i].st || got_ctl !== tbl[i].ctl) begin
            errors++;
            $display("FAIL vec%0d: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                     i, got_st, got_ctl, tbl[i].st, tbl[i].ctl);
         end
      end

      r1 = 1'b1;
      lat(OP_R, 6'b100001, 4, "addu");
      lat(OP_LW, 6'b000000, 5, "lw");
      lat(OP_SW, 6'b000000, 4, "sw");
      lat(OP_BEQ, 6'b000000, 3, "beq");
      lat(OP_JAL, 6'b000000, 2, "jal");
      lat(6'b111111, 6'b000000, 2, "illegal");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
